// File: rtl/mult_arbiter_if.sv
// Requester, multiplier and response signals of mult_arbiter.
// The arbiter connects through the master modport; the environment uses slave.
interface mult_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]    in_valid;
  logic [N_REQ-1:0]    in_ready;
  logic [N_REQ*16-1:0] in_arg_a;
  logic [N_REQ*16-1:0] in_arg_b;
  logic [N_REQ-1:0]    in_arg_a_parity;
  logic [N_REQ-1:0]    in_arg_b_parity;

  logic                mult_req;
  logic [15:0]         mult_arg_a;
  logic [15:0]         mult_arg_b;
  logic                mult_arg_a_parity;
  logic                mult_arg_b_parity;
  logic [31:0]         mult_result;
  logic                mult_result_parity;
  logic                mult_arg_parity_error;
  logic                mult_result_rdy;

  logic                out_valid;
  logic [IDW-1:0]      out_id;
  logic [31:0]         out_result;
  logic                out_result_parity;
  logic                out_arg_parity_error;
  logic                out_timeout;
  logic [15:0]         done_cnt;

  modport master (
    input  in_valid, in_arg_a, in_arg_b, in_arg_a_parity, in_arg_b_parity,
    input  mult_result, mult_result_parity, mult_arg_parity_error, mult_result_rdy,
    output in_ready,
    output mult_req, mult_arg_a, mult_arg_b, mult_arg_a_parity, mult_arg_b_parity,
    output out_valid, out_id, out_result, out_result_parity, out_arg_parity_error,
    output out_timeout, done_cnt
  );

  modport slave (
    output in_valid, in_arg_a, in_arg_b, in_arg_a_parity, in_arg_b_parity,
    output mult_result, mult_result_parity, mult_arg_parity_error, mult_result_rdy,
    input  in_ready,
    input  mult_req, mult_arg_a, mult_arg_b, mult_arg_a_parity, mult_arg_b_parity,
    input  out_valid, out_id, out_result, out_result_parity, out_arg_parity_error,
    input  out_timeout, done_cnt
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one parity-checked 16x16 multiplier between
// N_REQ requesters, with timeout abort and an ID-tagged response pulse.
module mult_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.master bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam logic [15:0]    TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           grant_vld;
  logic [IDW+3:0] base;
  logic [15:0]    to_cnt;

  assign base = {grant, 4'd0};

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin : grant_search
    int unsigned    idx;
    logic [IDW-1:0] idx_w;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 32'(rr_ptr) + i;
      if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
      idx_w = IDW'(idx);
      if (!grant_vld && bus.in_valid[idx_w]) begin
        grant_vld = 1'b1;
        grant     = idx_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld && !rst) begin
          bus.in_ready[grant] = 1'b1;
          state_nxt           = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mult_result_rdy || to_cnt == TO_LAST) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mult_req             <= 1'b0;
      bus.mult_arg_a           <= '0;
      bus.mult_arg_b           <= '0;
      bus.mult_arg_a_parity    <= 1'b0;
      bus.mult_arg_b_parity    <= 1'b0;
      bus.out_valid            <= 1'b0;
      bus.out_id               <= '0;
      bus.out_result           <= '0;
      bus.out_result_parity    <= 1'b0;
      bus.out_arg_parity_error <= 1'b0;
      bus.out_timeout          <= 1'b0;
      bus.done_cnt             <= '0;
      rr_ptr                   <= '0;
      to_cnt                   <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            bus.mult_req          <= 1'b1;
            bus.mult_arg_a        <= bus.in_arg_a[base +: 16];
            bus.mult_arg_b        <= bus.in_arg_b[base +: 16];
            bus.mult_arg_a_parity <= bus.in_arg_a_parity[grant];
            bus.mult_arg_b_parity <= bus.in_arg_b_parity[grant];
            bus.out_id            <= grant;
            rr_ptr                <= (grant == ID_LAST) ? '0 : grant + IDW'(1);
            to_cnt                <= '0;
          end
        end
        ISSUE: begin
          if (bus.mult_result_rdy) begin
            bus.mult_req             <= 1'b0;
            bus.out_valid            <= 1'b1;
            bus.out_result           <= bus.mult_result;
            bus.out_result_parity    <= bus.mult_result_parity;
            bus.out_arg_parity_error <= bus.mult_arg_parity_error;
            bus.out_timeout          <= 1'b0;
            bus.done_cnt             <= bus.done_cnt + 16'd1;
          end else if (to_cnt == TO_LAST) begin
            bus.mult_req             <= 1'b0;
            bus.out_valid            <= 1'b1;
            bus.out_result           <= '0;
            bus.out_result_parity    <= 1'b0;
            bus.out_arg_parity_error <= 1'b0;
            bus.out_timeout          <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: timeline model plus directed vectors.
module tb_mult_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  typedef logic [N*16-1:0] argv_t;
  typedef logic [N-1:0]    vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.N_REQ(N)) bus ();
  mult_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Requester agent state: main writes ra/rb/rap/rbp/req_cnt, agent owns sent.
  logic [15:0] ra [N] = '{default: '0};
  logic [15:0] rb [N] = '{default: '0};
  logic        rap[N] = '{default: 1'b0};
  logic        rbp[N] = '{default: 1'b0};
  int req_cnt[N] = '{default: 0};
  int sent[N]    = '{default: 0};
  int gq[$];
  int acc_cyc = 0;

  initial begin
    argv_t va, vb;
    vec_t  vv, vap, vbp;
    bus.in_valid = '0;
    bus.in_arg_a = '0;
    bus.in_arg_b = '0;
    bus.in_arg_a_parity = '0;
    bus.in_arg_b_parity = '0;
    forever begin
      @(posedge clk); #1;
      va = '0; vb = '0; vv = '0; vap = '0; vbp = '0;
      for (int i = 0; i < N; i++) begin
        va  = va  | (argv_t'(ra[i]) << (16 * i));
        vb  = vb  | (argv_t'(rb[i]) << (16 * i));
        vv  = vv  | (vec_t'(req_cnt[i] != sent[i]) << i);
        vap = vap | (vec_t'(rap[i]) << i);
        vbp = vbp | (vec_t'(rbp[i]) << i);
      end
      bus.in_valid = vv;
      bus.in_arg_a = va;
      bus.in_arg_b = vb;
      bus.in_arg_a_parity = vap;
      bus.in_arg_b_parity = vbp;
      @(negedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (1'(bus.in_ready >> i)) begin
          sent[i]++;
          gq.push_back(i);
          acc_cyc = cyc;
        end
      end
    end
  end

  // Multiplier stand-in: rdy mlat cycles into a request (0 = never), plus stray pulses.
  int mlat = 3;
  int stray_req = 0;
  int stray_ack = 0;
  initial begin
    int age;
    logic pe;
    logic signed [31:0] prod;
    age = 0;
    bus.mult_result = '0;
    bus.mult_result_parity = 1'b0;
    bus.mult_arg_parity_error = 1'b0;
    bus.mult_result_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      age = bus.mult_req ? age + 1 : 0;
      bus.mult_result_rdy = (mlat != 0 && age == mlat) || (stray_req != stray_ack);
      stray_ack = stray_req;
      pe = ((^bus.mult_arg_a) != bus.mult_arg_a_parity) ||
           ((^bus.mult_arg_b) != bus.mult_arg_b_parity);
      prod = $signed(bus.mult_arg_a) * $signed(bus.mult_arg_b);
      bus.mult_result = pe ? 32'd0 : prod;
      bus.mult_result_parity = ^bus.mult_result;
      bus.mult_arg_parity_error = pe;
    end
  end

  // Timeline model: a transaction accepted at cycle t issues until rdy or age TO,
  // then responds for exactly one cycle.
  initial begin
    bit busy, resp;
    int t_acc, last, g;
    logic [15:0] av[N], bv[N];
    logic apv[N], bpv[N], vv[N];
    logic [15:0] e_a, e_b, e_done;
    logic e_ap, e_bp, e_rp, e_pe, e_to;
    logic [1:0]  e_id;
    logic [31:0] e_res;
    vec_t e_rdy;
    busy = 0; resp = 0; t_acc = 0; last = N - 1;
    e_a = '0; e_b = '0; e_ap = 0; e_bp = 0; e_id = '0;
    e_res = '0; e_rp = 0; e_pe = 0; e_to = 0; e_done = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        av[i]  = 16'(bus.in_arg_a >> (16 * i));
        bv[i]  = 16'(bus.in_arg_b >> (16 * i));
        apv[i] = 1'(bus.in_arg_a_parity >> i);
        bpv[i] = 1'(bus.in_arg_b_parity >> i);
        vv[i]  = 1'(bus.in_valid >> i);
      end
      g = -1;
      if (!rst && !busy) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && vv[(last + k) % N]) g = (last + k) % N;
        end
      end
      e_rdy = (g >= 0) ? (vec_t'(1) << g) : '0;
      if (chk_en) begin
        chk("in_ready",    32'(bus.in_ready), 32'(e_rdy));
        chk("mult_req",    32'(bus.mult_req), 32'(busy && !resp));
        chk("out_valid",   32'(bus.out_valid), 32'(resp));
        chk("mult_arg_a",  32'(bus.mult_arg_a), 32'(e_a));
        chk("mult_arg_b",  32'(bus.mult_arg_b), 32'(e_b));
        chk("mult_a_par",  32'(bus.mult_arg_a_parity), 32'(e_ap));
        chk("mult_b_par",  32'(bus.mult_arg_b_parity), 32'(e_bp));
        chk("out_id",      32'(bus.out_id), 32'(e_id));
        chk("out_result",  bus.out_result, e_res);
        chk("out_res_par", 32'(bus.out_result_parity), 32'(e_rp));
        chk("out_par_err", 32'(bus.out_arg_parity_error), 32'(e_pe));
        chk("out_timeout", 32'(bus.out_timeout), 32'(e_to));
        chk("done_cnt",    32'(bus.done_cnt), 32'(e_done));
      end
      if (rst) begin
        busy = 0; resp = 0; last = N - 1;
        e_a = '0; e_b = '0; e_ap = 0; e_bp = 0; e_id = '0;
        e_res = '0; e_rp = 0; e_pe = 0; e_to = 0; e_done = '0;
      end else if (resp) begin
        busy = 0; resp = 0;
      end else if (busy) begin
        if (bus.mult_result_rdy) begin
          e_res = bus.mult_result; e_rp = bus.mult_result_parity;
          e_pe = bus.mult_arg_parity_error; e_to = 0;
          e_done = e_done + 16'd1; resp = 1;
        end else if (cyc - t_acc == TO) begin
          e_res = '0; e_rp = 0; e_pe = 0; e_to = 1; resp = 1;
        end
      end else if (g >= 0) begin
        busy = 1; t_acc = cyc; last = g; e_id = 2'(g);
        e_a = av[g]; e_b = bv[g]; e_ap = apv[g]; e_bp = bpv[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send_raw(input int i, input logic [15:0] a, input logic ap,
                          input logic [15:0] b, input logic bp);
    ra[i] = a; rb[i] = b; rap[i] = ap; rbp[i] = bp;
    req_cnt[i]++;
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
    send_raw(i, a, ^a, b, ^b);
  endtask

  task automatic wait_resp(input int max, output int rc);
    rc = -1;
    for (int n = 0; n < max && rc < 0; n++) begin
      @(negedge clk); #1;
      if (bus.out_valid) rc = cyc;
    end
    chk("wait_resp", 32'(rc >= 0), 32'd1);
  endtask

  task automatic wait_req(input int max);
    bit seen;
    seen = 0;
    for (int n = 0; n < max && !seen; n++) begin
      @(negedge clk); #1;
      seen = bus.mult_req;
    end
    chk("wait_req", 32'(seen), 32'd1);
  endtask

  initial begin
    int rc;
    int exp_ord[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // single request: 3 * -5 from requester 2, rdy on the 3rd request cycle
    mlat = 3;
    send(2, 16'd3, 16'hFFFB);
    wait_resp(30, rc);
    chk("t1_id",   32'(bus.out_id), 32'd2);
    chk("t1_res",  bus.out_result, 32'hFFFF_FFF1);
    chk("t1_perr", 32'(bus.out_arg_parity_error), 32'd0);
    chk("t1_done", 32'(bus.done_cnt), 32'd1);
    chk("t1_lat",  32'(rc - acc_cyc), 32'd4);

    // reset while idle, then fairness with every requester holding valid
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_done", 32'(bus.done_cnt), 32'd0);
    gq.delete();
    mlat = 2;
    for (int i = 0; i < N; i++) begin
      send(i, 16'(10 + i), 16'(i + 1));
      send(i, 16'(10 + i), 16'(i + 1));
    end
    for (int k = 0; k < 8; k++) wait_resp(40, rc);
    chk("fair_cnt", 32'(gq.size()), 32'd8);
    for (int k = 0; k < 8 && k < gq.size(); k++) chk("fair_order", 32'(gq[k]), 32'(exp_ord[k]));
    chk("fair_done", 32'(bus.done_cnt), 32'd8);

    // parity error on operand a passes through untouched
    send_raw(0, 16'h0001, 1'b0, 16'h0002, 1'b1);
    wait_req(20);
    chk("par_arg_ap", 32'(bus.mult_arg_a_parity), 32'd0);
    chk("par_arg_a",  32'(bus.mult_arg_a), 32'd1);
    wait_resp(30, rc);
    chk("par_perr", 32'(bus.out_arg_parity_error), 32'd1);
    chk("par_res",  bus.out_result, 32'd0);
    chk("par_done", 32'(bus.done_cnt), 32'd9);

    // timeout, followed by a stray rdy two cycles later
    mlat = 0;
    send(1, 16'd7, 16'd7);
    wait_resp(30, rc);
    chk("to_flag", 32'(bus.out_timeout), 32'd1);
    chk("to_res",  bus.out_result, 32'd0);
    chk("to_done", 32'(bus.done_cnt), 32'd9);
    chk("to_lat",  32'(rc - acc_cyc), 32'(TO + 1));
    tick(); tick();
    stray_req++;
    repeat (4) tick();
    chk("stray_done", 32'(bus.done_cnt), 32'd9);

    // boundary operands, and rdy on the final timeout cycle
    mlat = 1;
    send(2, 16'h8000, 16'h8000);
    wait_resp(30, rc);
    chk("bnd_res",  bus.out_result, 32'h4000_0000);
    chk("bnd_done", 32'(bus.done_cnt), 32'd10);
    chk("bnd_lat",  32'(rc - acc_cyc), 32'd2);
    mlat = TO;
    send(3, 16'd100, 16'hFFFE);
    wait_resp(30, rc);
    chk("edge_to",   32'(bus.out_timeout), 32'd0);
    chk("edge_res",  bus.out_result, 32'hFFFF_FF38);
    chk("edge_done", 32'(bus.done_cnt), 32'd11);
    chk("edge_lat",  32'(rc - acc_cyc), 32'(TO + 1));

    // reset during ISSUE drops the request; a late rdy must do nothing
    mlat = 0;
    send(1, 16'd5, 16'd5);
    wait_req(20);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_req",  32'(bus.mult_req), 32'd0);
    chk("mrst_arg",  32'(bus.mult_arg_a), 32'd0);
    chk("mrst_res",  bus.out_result, 32'd0);
    chk("mrst_id",   32'(bus.out_id), 32'd0);
    chk("mrst_done", 32'(bus.done_cnt), 32'd0);
    stray_req++;
    repeat (5) tick();

    // pointer restarts at 0: requester 1 beats requester 3
    gq.delete();
    mlat = 2;
    send(3, 16'd6, 16'd7);
    send(1, 16'd2, 16'd9);
    wait_resp(30, rc);
    wait_resp(30, rc);
    chk("ptr_cnt", 32'(gq.size()), 32'd2);
    if (gq.size() >= 2) begin
      chk("ptr_first",  32'(gq[0]), 32'd1);
      chk("ptr_second", 32'(gq[1]), 32'd3);
    end
    chk("ptr_res",  bus.out_result, 32'd42);
    chk("ptr_done", 32'(bus.done_cnt), 32'd2);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
